// File: rtl/snake_pkg.sv
// Shared definitions for the snake body store: direction codes, FSM states
// and the default screen geometry.
package snake_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_SHIFT,
    ST_SCAN,
    ST_FIN
  } state_e;

  localparam int unsigned XSCREEN = 160;
  localparam int unsigned YSCREEN = 120;
  localparam int unsigned CELL    = 10;

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculation: one CELL step along the direction axis,
// with edge detection and optional wrap-around.
module snake_next_head #(
  parameter int unsigned XW      = 8,
  parameter int unsigned YW      = 7,
  parameter int unsigned CELL    = 10,
  parameter int unsigned XSCREEN = 160,
  parameter int unsigned YSCREEN = 120,
  parameter int unsigned WRAP    = 0
) (
  input  logic [XW-1:0] head_x,
  input  logic [YW-1:0] head_y,
  input  logic [1:0]    dir,
  output logic [XW-1:0] new_x,
  output logic [YW-1:0] new_y,
  output logic          at_edge
);
  import snake_pkg::*;

  localparam logic [XW:0] X_MAX  = (XW+1)'(XSCREEN - CELL);
  localparam logic [YW:0] Y_MAX  = (YW+1)'(YSCREEN - CELL);
  localparam logic [XW:0] X_STEP = (XW+1)'(CELL);
  localparam logic [YW:0] Y_STEP = (YW+1)'(CELL);

  logic [XW:0] x_inc, x_dec;
  logic [YW:0] y_inc, y_dec;

  // An underflowing decrement lands far above the max, so one compare
  // covers both the "< 0" and "past the far edge" conditions.
  always_comb begin
    x_inc   = {1'b0, head_x} + X_STEP;
    x_dec   = {1'b0, head_x} - X_STEP;
    y_inc   = {1'b0, head_y} + Y_STEP;
    y_dec   = {1'b0, head_y} - Y_STEP;
    new_x   = head_x;
    new_y   = head_y;
    at_edge = 1'b0;
    unique case (dir)
      DIR_RIGHT: begin
        if (x_inc > X_MAX) begin
          at_edge = 1'b1;
          new_x   = '0;
        end else begin
          new_x = x_inc[XW-1:0];
        end
      end
      DIR_LEFT: begin
        if (x_dec > X_MAX) begin
          at_edge = 1'b1;
          new_x   = X_MAX[XW-1:0];
        end else begin
          new_x = x_dec[XW-1:0];
        end
      end
      DIR_DOWN: begin
        if (y_inc > Y_MAX) begin
          at_edge = 1'b1;
          new_y   = '0;
        end else begin
          new_y = y_inc[YW-1:0];
        end
      end
      DIR_UP: begin
        if (y_dec > Y_MAX) begin
          at_edge = 1'b1;
          new_y   = Y_MAX[YW-1:0];
        end else begin
          new_y = y_dec[YW-1:0];
        end
      end
      default: ;
    endcase
    if (at_edge && (WRAP == 0)) begin
      new_x = head_x;
      new_y = head_y;
    end
  end

endmodule

// File: rtl/snake_body_store.sv
// Snake body segment store: moves the head, shifts/grows the body, scans for
// self-collision and serves an indexed registered read port.
module snake_body_store #(
  parameter int unsigned XW       = 8,
  parameter int unsigned YW       = 7,
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned INIT_LEN = 4,
  parameter int unsigned CELL     = snake_pkg::CELL,
  parameter int unsigned X_INIT   = 80,
  parameter int unsigned Y_INIT   = 60,
  parameter int unsigned XSCREEN  = snake_pkg::XSCREEN,
  parameter int unsigned YSCREEN  = snake_pkg::YSCREEN,
  parameter int unsigned WRAP     = 0,
  localparam int unsigned IW      = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  input  logic [1:0]    dir,
  input  logic          grow,
  input  logic [IW-1:0] rd_idx,
  output logic [XW-1:0] rd_x,
  output logic [YW-1:0] rd_y,
  output logic [IW:0]   length,
  output logic          busy,
  output logic          done,
  output logic          collide,
  output logic          wall_hit
);
  import snake_pkg::*;

  localparam logic [IW:0] LEN_INIT = (IW+1)'(INIT_LEN);
  localparam logic [IW:0] LEN_MAX  = (IW+1)'(MAX_LEN);
  localparam logic [IW:0] LEN_ONE  = (IW+1)'(1);

  state_e        state_q, state_d;
  logic [XW-1:0] seg_x_q [MAX_LEN];
  logic [XW-1:0] seg_x_d [MAX_LEN];
  logic [YW-1:0] seg_y_q [MAX_LEN];
  logic [YW-1:0] seg_y_d [MAX_LEN];
  logic [IW:0]   len_q, len_d;
  logic [IW-1:0] scan_k_q, scan_k_d;
  logic [1:0]    cur_dir_q, cur_dir_d;
  logic [1:0]    req_dir_q, req_dir_d;
  logic [1:0]    eff_dir;
  logic          grow_q, grow_d;
  logic          collide_q, collide_d;
  logic          wall_hit_q, wall_hit_d;
  logic          done_q, done_d;
  logic [XW-1:0] rd_x_q, rd_x_d;
  logic [YW-1:0] rd_y_q, rd_y_d;
  logic [IW-1:0] rd_sel;
  logic [XW-1:0] nh_x;
  logic [YW-1:0] nh_y;
  logic          nh_edge;

  // Stays valid through SHIFT: once cur_dir takes the request, the request
  // is no longer a reversal of it, so the same direction results.
  assign eff_dir = (req_dir_q == (cur_dir_q ^ 2'b11)) ? cur_dir_q : req_dir_q;

  snake_next_head #(
    .XW      (XW),
    .YW      (YW),
    .CELL    (CELL),
    .XSCREEN (XSCREEN),
    .YSCREEN (YSCREEN),
    .WRAP    (WRAP)
  ) u_next_head (
    .head_x  (seg_x_q[0]),
    .head_y  (seg_y_q[0]),
    .dir     (eff_dir),
    .new_x   (nh_x),
    .new_y   (nh_y),
    .at_edge (nh_edge)
  );

  always_comb begin
    state_d    = state_q;
    seg_x_d    = seg_x_q;
    seg_y_d    = seg_y_q;
    len_d      = len_q;
    scan_k_d   = scan_k_q;
    cur_dir_d  = cur_dir_q;
    req_dir_d  = req_dir_q;
    grow_d     = grow_q;
    collide_d  = collide_q;
    wall_hit_d = wall_hit_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (step && !collide_q) begin
          req_dir_d = dir;
          grow_d    = grow;
          state_d   = ST_CALC;
        end
      end
      ST_CALC: begin
        cur_dir_d = eff_dir;
        if (nh_edge && (WRAP == 0)) begin
          wall_hit_d = 1'b1;
          state_d    = ST_FIN;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
          seg_x_d[i] = seg_x_q[i-1];
          seg_y_d[i] = seg_y_q[i-1];
        end
        seg_x_d[0] = nh_x;
        seg_y_d[0] = nh_y;
        if (grow_q && (len_q < LEN_MAX)) len_d = len_q + LEN_ONE;
        scan_k_d = IW'(1);
        state_d  = (len_d > LEN_ONE) ? ST_SCAN : ST_FIN;
      end
      ST_SCAN: begin
        if ((seg_x_q[scan_k_q] == seg_x_q[0]) && (seg_y_q[scan_k_q] == seg_y_q[0]))
          collide_d = 1'b1;
        if ({1'b0, scan_k_q} == (len_q - LEN_ONE)) state_d = ST_FIN;
        else                                       scan_k_d = scan_k_q + 1'b1;
      end
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Read from next-state contents so a read during SHIFT sees the moved body.
    rd_sel = ({1'b0, rd_idx} >= len_d) ? IW'(len_d - LEN_ONE) : rd_idx;
    rd_x_d = seg_x_d[rd_sel];
    rd_y_d = seg_y_d[rd_sel];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= LEN_INIT;
      scan_k_q   <= '0;
      cur_dir_q  <= DIR_UP;
      req_dir_q  <= DIR_UP;
      grow_q     <= 1'b0;
      collide_q  <= 1'b0;
      wall_hit_q <= 1'b0;
      done_q     <= 1'b0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= XW'(X_INIT);
        seg_y_q[i] <= YW'(Y_INIT + ((i < INIT_LEN) ? i : (INIT_LEN - 1)) * CELL);
      end
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      scan_k_q   <= scan_k_d;
      cur_dir_q  <= cur_dir_d;
      req_dir_q  <= req_dir_d;
      grow_q     <= grow_d;
      collide_q  <= collide_d;
      wall_hit_q <= wall_hit_d;
      done_q     <= done_d;
      rd_x_q     <= rd_x_d;
      rd_y_q     <= rd_y_d;
      seg_x_q    <= seg_x_d;
      seg_y_q    <= seg_y_d;
    end
  end

  assign rd_x     = rd_x_q;
  assign rd_y     = rd_y_q;
  assign length   = len_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign collide  = collide_q;
  assign wall_hit = wall_hit_q;

endmodule

// File: tb/tb_snake_body_store.sv
// Directed bench for snake_body_store: blocking, wrapping and full-capacity
// instances driven by one shared step/read stimulus.
module tb_snake_body_store;

  logic       clk, reset, step, grow;
  logic [1:0] dir;
  logic [3:0] rd_idx;

  logic [7:0] rd_x0, rd_xw, rd_xm;
  logic [6:0] rd_y0, rd_yw, rd_ym;
  logic [4:0] len0, lenw;
  logic [2:0] lenm;
  logic       busy0, busyw, busym, done0, donew, donem;
  logic       coll0, collw, collm, wall0, wallw, wallm;

  int n_err = 0;
  int n_checks = 0;
  int lat0, latw, latm;

  snake_body_store #(.WRAP(0)) dut (
    .clk(clk), .reset(reset), .step(step), .dir(dir), .grow(grow), .rd_idx(rd_idx),
    .rd_x(rd_x0), .rd_y(rd_y0), .length(len0), .busy(busy0), .done(done0),
    .collide(coll0), .wall_hit(wall0));

  snake_body_store #(.WRAP(1)) dut_w (
    .clk(clk), .reset(reset), .step(step), .dir(dir), .grow(grow), .rd_idx(rd_idx),
    .rd_x(rd_xw), .rd_y(rd_yw), .length(lenw), .busy(busyw), .done(donew),
    .collide(collw), .wall_hit(wallw));

  snake_body_store #(.MAX_LEN(4), .INIT_LEN(4), .WRAP(0)) dut_m (
    .clk(clk), .reset(reset), .step(step), .dir(dir), .grow(grow), .rd_idx(rd_idx[1:0]),
    .rd_x(rd_xm), .rd_y(rd_ym), .length(lenm), .busy(busym), .done(donem),
    .collide(collm), .wall_hit(wallm));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int x;
    int y;
  } rd_vec_t;

  typedef struct {
    logic [1:0] d;
    logic       g;
    int         hx;
    int         hy;
    int         len;
    int         lat;   // 0 = latency not checked
    int         wall;
    int         coll;
  } step_vec_t;

  rd_vec_t   rst_tbl[5];
  step_vec_t stp_tbl[11];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic read_all(input int idx);
    @(negedge clk);
    rd_idx = idx[3:0];
    @(posedge clk);
    #1;
  endtask

  task automatic do_step(input int id, input logic [1:0] d, input logic g);
    lat0 = -1; latw = -1; latm = -1;
    @(negedge clk);
    dir = d; grow = g; step = 1'b1;
    @(posedge clk);
    #1;
    step = 1'b0; grow = 1'b0;
    check($sformatf("step%0d busy", id), int'(busy0), 1);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done0 && lat0 < 0) lat0 = c;
      if (donew && latw < 0) latw = c;
      if (donem && latm < 0) latm = c;
      if (lat0 >= 0 && latw >= 0 && latm >= 0) break;
    end
  endtask

  initial begin
    int busy_seen, done_seen;
    rst_tbl[0] = '{0, 80, 60};
    rst_tbl[1] = '{1, 80, 70};
    rst_tbl[2] = '{2, 80, 80};
    rst_tbl[3] = '{3, 80, 90};
    rst_tbl[4] = '{9, 80, 90};

    stp_tbl[0]  = '{2'd0, 1'b0,  90, 60, 4, 6, 0, 0};
    stp_tbl[1]  = '{2'd3, 1'b0, 100, 60, 4, 6, 0, 0};
    stp_tbl[2]  = '{2'd0, 1'b1, 110, 60, 5, 0, 0, 0};
    stp_tbl[3]  = '{2'd0, 1'b0, 120, 60, 5, 7, 0, 0};
    stp_tbl[4]  = '{2'd0, 1'b0, 130, 60, 5, 7, 0, 0};
    stp_tbl[5]  = '{2'd0, 1'b0, 140, 60, 5, 7, 0, 0};
    stp_tbl[6]  = '{2'd0, 1'b0, 150, 60, 5, 7, 0, 0};
    stp_tbl[7]  = '{2'd0, 1'b0, 150, 60, 5, 2, 1, 0};
    stp_tbl[8]  = '{2'd2, 1'b0, 150, 50, 5, 7, 1, 0};
    stp_tbl[9]  = '{2'd3, 1'b0, 140, 50, 5, 7, 1, 0};
    stp_tbl[10] = '{2'd1, 1'b0, 140, 60, 5, 7, 1, 1};

    reset = 1'b1; step = 1'b0; grow = 1'b0; dir = 2'd0; rd_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset rd_x", int'(rd_x0), 0);
    check("reset rd_y", int'(rd_y0), 0);
    check("reset length", int'(len0), 4);
    check("reset busy", int'(busy0), 0);
    check("reset done", int'(done0), 0);
    check("reset collide", int'(coll0), 0);
    check("reset wall_hit", int'(wall0), 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (rst_tbl[i]) begin
      read_all(rst_tbl[i].idx);
      check($sformatf("reset seg%0d x", rst_tbl[i].idx), int'(rd_x0), rst_tbl[i].x);
      check($sformatf("reset seg%0d y", rst_tbl[i].idx), int'(rd_y0), rst_tbl[i].y);
    end

    foreach (stp_tbl[i]) begin
      do_step(i, stp_tbl[i].d, stp_tbl[i].g);
      if (stp_tbl[i].lat != 0)
        check($sformatf("step%0d latency", i), lat0, stp_tbl[i].lat);
      else
        check($sformatf("step%0d done seen", i), int'(lat0 > 0), 1);
      read_all(0);
      check($sformatf("step%0d head x", i), int'(rd_x0), stp_tbl[i].hx);
      check($sformatf("step%0d head y", i), int'(rd_y0), stp_tbl[i].hy);
      check($sformatf("step%0d length", i), int'(len0), stp_tbl[i].len);
      check($sformatf("step%0d wall_hit", i), int'(wall0), stp_tbl[i].wall);
      check($sformatf("step%0d collide", i), int'(coll0), stp_tbl[i].coll);
      case (i)
        0: begin
          read_all(1);
          check("step0 seg1 x", int'(rd_x0), 80);
          check("step0 seg1 y", int'(rd_y0), 60);
          read_all(3);
          check("step0 seg3 y", int'(rd_y0), 80);
        end
        2: begin
          read_all(4);
          check("grow seg4 x", int'(rd_x0), 80);
          check("grow seg4 y", int'(rd_y0), 70);
          read_all(7);
          check("grow tail read y", int'(rd_y0), 70);
          check("full len stays", int'(lenm), 4);
          check("full len latency", latm, 6);
        end
        7: begin
          read_all(1);
          check("blocked seg1 x", int'(rd_x0), 140);
          check("wrap latency", latw, 7);
          read_all(0);
          check("wrap head x", int'(rd_xw), 0);
          check("wrap head y", int'(rd_yw), 60);
          check("wrap wall_hit", int'(wallw), 0);
        end
        default: ;
      endcase
    end

    // Game over: a further step must be ignored entirely.
    busy_seen = 0; done_seen = 0;
    @(negedge clk);
    dir = 2'd1; step = 1'b1;
    @(posedge clk);
    #1;
    step = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (busy0) busy_seen = 1;
      if (done0) done_seen = 1;
      @(posedge clk);
      #1;
    end
    check("after collide busy", busy_seen, 0);
    check("after collide done", done_seen, 0);
    check("after collide sticky", int'(coll0), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/snake_body_store.md
Name: snake_body_store

Overview:
- Parametrised store for the snake body segment positions, one (x,y) pixel pair per segment.
- On each animation step it computes the new head from the current direction, handles wall hits by either wrapping or blocking, shifts the body and optionally grows by one.
- After the move it scans the body for self-collision.
- Sits between the direction/FSM control and the VGA draw sequencer; the sequencer reads segments through an indexed read port.

Parameters:
- XW, 8: x coordinate width
- YW, 7: y coordinate width
- MAX_LEN, 16: segment capacity, >=2
- INIT_LEN, 4: length after reset, 1..MAX_LEN
- CELL, 10: segment pitch in pixels
- X_INIT, 80: reset head x
- Y_INIT, 60: reset head y
- XSCREEN, 160: screen width in pixels
- YSCREEN, 120: screen height in pixels
- WRAP, 0: 1 = wrap at screen edges; 0 = block at edges and flag
- IW, $clog2(MAX_LEN): index and length field width, computed locally

Ports:
- clk, in, 1: system clock
- reset, in, 1: asynchronous, active-high
- step, in, 1: single-cycle pulse requesting one move
- dir, in, 2: requested direction; 0 right, 1 down, 2 up, 3 left
- grow, in, 1: sampled together with step; extends length by 1
- rd_idx, in, IW: segment index for the read port; 0 = head
- rd_x, out, XW: x of segment rd_idx, registered
- rd_y, out, YW: y of segment rd_idx, registered
- length, out, IW+1: current segment count
- busy, out, 1: move or scan in progress
- done, out, 1: one-cycle pulse at the end of a step
- collide, out, 1: sticky; head overlaps a body segment
- wall_hit, out, 1: sticky, WRAP=0 only; a blocked move against an edge

Behaviour:
- Reset (asynchronous, on reset high):
  - seg[i] = (X_INIT, Y_INIT + i*CELL) for i < INIT_LEN; seg[i] = seg[INIT_LEN-1] for the remaining slots.
  - length = INIT_LEN; cur_dir = 2 (up); FSM state = IDLE.
  - busy, done, collide, wall_hit = 0; rd_x, rd_y = 0.
- Reset asserted mid-operation aborts the step; no partial shift is retained.
- FSM states: IDLE, CALC, SHIFT, SCAN, FIN.
- IDLE:
  - If step=1, latch dir and grow, go to CALC, busy=1.
  - If collide=1, step is ignored (game over until reset).
- CALC, 1 cycle:
  - Direction: if dir == cur_dir ^ 2'b11 (reversal), keep cur_dir; otherwise cur_dir <= dir.
  - New head = seg[0] ± CELL on the axis of the effective direction. Arithmetic is XW+1 / YW+1 bits, unsigned.
  - Edge condition: the result would be < 0, or > XSCREEN-CELL (x axis) / > YSCREEN-CELL (y axis).
  - WRAP=1 at an edge: leaving right lands at 0; leaving left lands at XSCREEN-CELL; same scheme on the y axis.
  - WRAP=0 at an edge: wall_hit <= 1, skip to FIN; no shift, no grow.
- SHIFT, 1 cycle:
  - seg[i] <= seg[i-1] for 1 <= i < MAX_LEN; seg[0] <= new head.
  - If grow latched and length < MAX_LEN: length <= length+1. The new tail is the old last segment, which the shift duplicates.
  - grow at length == MAX_LEN is ignored silently.
- SCAN: one comparison per cycle, k = 1 .. length-1.
  - If seg[k] == seg[0]: collide <= 1.
  - Scan runs to completion regardless.
  - Latency is length-1 cycles; with length=1 SCAN takes 0 cycles.
- FIN, 1 cycle: done=1, busy=0, return to IDLE.
- Step latency, step pulse to done:
  - 3 + (length-1) cycles for a normal move.
  - 2 cycles for a blocked move.
- Read port:
  - rd_x/rd_y <= seg[rd_idx] every cycle; latency is 1 cycle.
  - rd_idx >= length returns the tail position.
  - Values read during SHIFT are valid on the next cycle with the new contents.
- step while busy=1 is ignored; no queueing.

Decomposition:
- Shared package snake_pkg:
  - Direction encodings DIR_RIGHT/DOWN/UP/LEFT.
  - FSM state enum.
  - Screen constants XSCREEN, YSCREEN, CELL.
- One natural sub-module: snake_next_head. Combinational; takes head, dir and WRAP and produces new_x, new_y, edge.
- Segment array, length counter, FSM and scan counter live in the top module.

Test Plan:
- Reset with defaults, read idx 0..3 -> (80,60),(80,70),(80,80),(80,90); length=4, busy=0.
- step, dir=0 (right), no grow -> done after 6 cycles; head (90,60); seg1 (80,60); seg3 (80,80); length=4; collide=0.
- step, dir=3 while cur_dir=0 (reversal) -> treated as right; head x +10.
- step with grow=1 -> length 4->5; seg4 equals the pre-step seg3. Repeat at length=MAX_LEN -> length stays at MAX_LEN.
- Edge cases with head at (150,60) stepping right:
  - WRAP=0 -> wall_hit=1, positions unchanged, done after 2 cycles.
  - WRAP=1 -> head (0,60), wall_hit=0.
- Grow to length 5, then steps up, right, down, left -> head returns to an occupied cell; collide=1 at done; a further step produces no busy and no done.
